// File: rtl/pds_resp_pkg.sv
// Shared types and constants for the PDS-side 68000 register-window responder.
package pds_resp_pkg;

    localparam int WAITS_W = 4;
    localparam logic [15:0] DEF_ID_VAL = 16'h5753;

    localparam logic [1:0] REG_CFG0 = 2'd0;
    localparam logic [1:0] REG_CFG1 = 2'd1;
    localparam logic [1:0] REG_CFG2 = 2'd2;
    localparam logic [1:0] REG_ID   = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACK,
        VPAW,
        HOLD
    } stateT;

    // Byte-lane merge; strobes are active-low as seen on the bus.
    function automatic logic [15:0] laneMerge(input logic [15:0] cur,
                                              input logic [15:0] wd,
                                              input logic        udsN,
                                              input logic        ldsN);
        logic [15:0] res;
        res = cur;
        if (!udsN) res[15:8] = wd[15:8];
        if (!ldsN) res[7:0]  = wd[7:0];
        return res;
    endfunction

endpackage

// File: rtl/pds_resp_sync2.sv
// Two-flop synchroniser with a selectable reset value.
// Latency 2 CLK edges; no backpressure.
module pds_resp_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RES,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK) begin
        if (RES) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pds_resp.sv
// 68000 bus target for the on-card register window: nDTACK or nVPA/E termination.
// nDTACK at edge k+3+WAITS after nAS is first sampled low; release 2 edges after nAS high is sampled.
module pds_resp
    import pds_resp_pkg::*;
#(
    parameter logic [WAITS_W-1:0] WAITS   = 4'd2,
    parameter logic [15:0]        ID_VAL  = DEF_ID_VAL,
    parameter logic [15:0]        RST_CFG = 16'h0000
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [7:1]  A,
    input  logic        CS,
    input  logic        nAS,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        RnW,
    input  logic        nVMA,
    input  logic        E,
    input  logic [15:0] Din,
    output logic [15:0] Dout,
    output logic        DOE,
    output logic        nDTACK,
    output logic        nVPA,
    output logic [15:0] CFG0,
    output logic [15:0] CFG1,
    output logic [15:0] CFG2
);

    logic asSync, udsSync, ldsSync, vmaSync, eSync;

    pds_resp_sync2 #(.RST_VAL(1'b1)) uSyncAs  (.CLK(CLK), .RES(RES), .d(nAS),  .q(asSync));
    pds_resp_sync2 #(.RST_VAL(1'b1)) uSyncUds (.CLK(CLK), .RES(RES), .d(nUDS), .q(udsSync));
    pds_resp_sync2 #(.RST_VAL(1'b1)) uSyncLds (.CLK(CLK), .RES(RES), .d(nLDS), .q(ldsSync));
    pds_resp_sync2 #(.RST_VAL(1'b1)) uSyncVma (.CLK(CLK), .RES(RES), .d(nVMA), .q(vmaSync));
    pds_resp_sync2 #(.RST_VAL(1'b0)) uSyncE   (.CLK(CLK), .RES(RES), .d(E),    .q(eSync));

    stateT               state, stateNxt;
    logic [WAITS_W-1:0]  cnt, cntNxt;
    logic                asPrev, ePrev;
    logic [1:0]          live;
    logic [15:0]         cfg [3];
    logic [15:0]         rdData;
    logic                start, eFall;
    logic                wrEn, setAck, setVpa, setOe, rel;
    logic                unusedAlias;

    assign unusedAlias = ^A[6:3];

    // The preset synchroniser value is not a real observation of the bus, so
    // the edge detector stays disarmed until the nAS pipeline holds pin data.
    // This keeps a strobe held low across reset from looking like a new cycle.
    assign start = asPrev & ~asSync;
    assign eFall = ePrev & ~eSync;

    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        wrEn     = 1'b0;
        setAck   = 1'b0;
        setVpa   = 1'b0;
        setOe    = 1'b0;
        rel      = 1'b0;
        case (state)
            IDLE: begin
                if (start && CS) begin
                    if (A[7]) begin
                        stateNxt = VPAW;
                        setVpa   = 1'b1;
                        setOe    = RnW;
                    end else begin
                        stateNxt = WAIT;
                        cntNxt   = WAITS;
                    end
                end
            end
            WAIT: begin
                if (asSync) begin
                    stateNxt = IDLE;
                    rel      = 1'b1;
                end else if (cnt == '0) begin
                    stateNxt = ACK;
                    setAck   = 1'b1;
                    setOe    = RnW;
                    wrEn     = ~RnW;
                end else begin
                    cntNxt = cnt - 1'b1;
                end
            end
            ACK: stateNxt = HOLD;
            VPAW: begin
                if (asSync) begin
                    stateNxt = IDLE;
                    rel      = 1'b1;
                end else if (!vmaSync && eFall) begin
                    stateNxt = HOLD;
                    wrEn     = ~RnW;
                end
            end
            HOLD: begin
                if (asSync) begin
                    stateNxt = IDLE;
                    rel      = 1'b1;
                end
            end
            default: begin
                stateNxt = IDLE;
                rel      = 1'b1;
            end
        endcase
    end

    always_comb begin
        rdData = ID_VAL;
        case (A[2:1])
            REG_CFG0: rdData = cfg[0];
            REG_CFG1: rdData = cfg[1];
            REG_CFG2: rdData = cfg[2];
            default:  rdData = ID_VAL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state  <= IDLE;
            cnt    <= '0;
            asPrev <= 1'b0;
            ePrev  <= 1'b0;
            live   <= 2'b00;
        end else begin
            state  <= stateNxt;
            cnt    <= cntNxt;
            asPrev <= live[1] ? asSync : 1'b0;
            ePrev  <= eSync;
            live   <= {live[0], 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            nDTACK <= 1'b1;
            nVPA   <= 1'b1;
            DOE    <= 1'b0;
            Dout   <= '0;
        end else if (rel) begin
            nDTACK <= 1'b1;
            nVPA   <= 1'b1;
            DOE    <= 1'b0;
            Dout   <= '0;
        end else begin
            if (setAck) nDTACK <= 1'b0;
            if (setVpa) nVPA   <= 1'b0;
            if (setOe) begin
                DOE  <= 1'b1;
                Dout <= rdData;
            end
        end
    end

    // Writes to the ID slot are acknowledged by the FSM but land nowhere.
    always_ff @(posedge CLK) begin
        if (RES) begin
            for (int i = 0; i < 3; i++) cfg[i] <= RST_CFG;
        end else if (wrEn) begin
            case (A[2:1])
                REG_CFG0: cfg[0] <= laneMerge(cfg[0], Din, udsSync, ldsSync);
                REG_CFG1: cfg[1] <= laneMerge(cfg[1], Din, udsSync, ldsSync);
                REG_CFG2: cfg[2] <= laneMerge(cfg[2], Din, udsSync, ldsSync);
                default: ;
            endcase
        end
    end

    assign CFG0 = cfg[0];
    assign CFG1 = cfg[1];
    assign CFG2 = cfg[2];

endmodule

// File: tb/tb_pds_resp.sv
// Directed and scoreboarded checks of pds_resp; a second instance with WAITS=10 covers the abort case.
module tb_pds_resp;

    logic        CLK = 1'b0;
    logic        RES, CS, nAS, nUDS, nLDS, RnW, nVMA, E;
    logic [7:1]  A;
    logic [15:0] Din;

    logic [15:0] Dout, CFG0, CFG1, CFG2;
    logic        DOE, nDTACK, nVPA;
    logic [15:0] Dout10, CFG0_10, CFG1_10, CFG2_10;
    logic        DOE10, nDTACK10, nVPA10;

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;
    logic [15:0] mdl [4];

    always #5 CLK = ~CLK;

    pds_resp #(.WAITS(4'd2), .ID_VAL(16'h5753), .RST_CFG(16'h0000)) dut (
        .CLK(CLK), .RES(RES), .A(A), .CS(CS), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS),
        .RnW(RnW), .nVMA(nVMA), .E(E), .Din(Din), .Dout(Dout), .DOE(DOE),
        .nDTACK(nDTACK), .nVPA(nVPA), .CFG0(CFG0), .CFG1(CFG1), .CFG2(CFG2)
    );

    pds_resp #(.WAITS(4'd10), .ID_VAL(16'h5753), .RST_CFG(16'h0000)) dut10 (
        .CLK(CLK), .RES(RES), .A(A), .CS(CS), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS),
        .RnW(RnW), .nVMA(nVMA), .E(E), .Din(Din), .Dout(Dout10), .DOE(DOE10),
        .nDTACK(nDTACK10), .nVPA(nVPA10), .CFG0(CFG0_10), .CFG1(CFG1_10), .CFG2(CFG2_10)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Step one edge and sample 1 ns later; also watch for DTACK/VPA overlap.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (!nDTACK && !nVPA) overlap++;
    endtask

    // Addresses are built as {A7, A6..A3, A2..A1}.
    function automatic logic [7:1] mkAddr(input logic vpa, input logic [3:0] alias4, input logic [1:0] idx);
        return {vpa, alias4, idx};
    endfunction

    // One bus cycle: nAS low for 14 edges (E falls mid-cycle for VPA), then
    // nAS high for 'gap' edges. Ticks 1-2 are skipped so a previous cycle's
    // release, which overlaps a 1-edge gap, is not mistaken for this one.
    task automatic busCycle(input logic cs, input logic [7:1] addr, input logic rnw,
                            input logic [15:0] din, input logic uds, input logic lds,
                            input int gap, output int ackTick, output int vpaTick,
                            output logic [15:0] rdDat, output logic sawOe, output logic oeAtAck);
        ackTick = 0; vpaTick = 0; rdDat = '0; sawOe = 1'b0; oeAtAck = 1'b0;
        CS = cs; A = addr; RnW = rnw; Din = din; nUDS = uds; nLDS = lds; nAS = 1'b0;
        for (int t = 1; t <= 14; t++) begin
            if (addr[7] && t == 4) begin nVMA = 1'b0; E = 1'b1; end
            if (addr[7] && t == 8) E = 1'b0;
            tick();
            if (t >= 3) begin
                if (!nDTACK && ackTick == 0) begin ackTick = t; oeAtAck = DOE; end
                if (!nVPA && vpaTick == 0) vpaTick = t;
                if (DOE) begin sawOe = 1'b1; rdDat = Dout; end
            end
        end
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; nVMA = 1'b1;
        repeat (gap) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack, vpa, a10;
        logic [15:0] rd;
        logic oe, oeAck, hit;
        logic [1:0] idx;
        logic rvpa, rrnw, ruds, rlds;
        logic [15:0] rdin;
        logic [3:0] ral;

        RES = 1'b1; CS = 1'b0; nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; RnW = 1'b1;
        nVMA = 1'b1; E = 1'b0; A = '0; Din = '0;
        repeat (2) tick();
        chk("rst_ndtack", 32'(nDTACK), 32'd1);
        chk("rst_nvpa",   32'(nVPA),   32'd1);
        chk("rst_doe",    32'(DOE),    32'd0);
        chk("rst_dout",   32'(Dout),   32'h0);
        chk("rst_cfg0",   32'(CFG0),   32'h0);
        chk("rst_cfg1",   32'(CFG1),   32'h0);
        chk("rst_cfg2",   32'(CFG2),   32'h0);
        RES = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) mdl[i] = 16'h0000;
        mdl[3] = 16'h5753;

        // Abort: the WAITS=10 instance sees nAS rise while still counting.
        CS = 1'b1; A = mkAddr(1'b0, 4'h0, 2'd2); RnW = 1'b0; Din = 16'hBEEF;
        nUDS = 1'b0; nLDS = 1'b0; nAS = 1'b0;
        ack = 0; hit = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (!nDTACK && ack == 0) ack = t;
            if (!nDTACK10 || !nVPA10 || DOE10) hit = 1'b1;
        end
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        repeat (14) begin
            tick();
            if (!nDTACK10 || !nVPA10 || DOE10) hit = 1'b1;
        end
        chk("abort_main_ack",  32'(ack), 32'd6);
        chk("abort_main_cfg2", 32'(CFG2), 32'hBEEF);
        chk("abort_w10_none",  32'(hit), 32'd0);
        chk("abort_w10_cfg",   32'({CFG0_10, CFG1_10} | {16'h0, CFG2_10}), 32'h0);
        chk("abort_w10_dout",  32'(Dout10), 32'h0);
        mdl[2] = 16'hBEEF;

        // Word write to reg1, then release timing.
        busCycle(1'b1, mkAddr(1'b0, 4'h0, 2'd1), 1'b0, 16'hA55A, 1'b0, 1'b0, 0, ack, vpa, rd, oe, oeAck);
        chk("w1_ack_tick", 32'(ack), 32'd6);
        chk("w1_cfg1",     32'(CFG1), 32'hA55A);
        tick(); tick();
        chk("w1_still_ack", 32'(nDTACK), 32'd0);
        tick();
        chk("w1_release",   32'(nDTACK), 32'd1);
        mdl[1] = 16'hA55A;

        busCycle(1'b1, mkAddr(1'b0, 4'h0, 2'd0), 1'b0, 16'h1234, 1'b1, 1'b0, 3, ack, vpa, rd, oe, oeAck);
        chk("bytew_cfg0", 32'(CFG0), 32'h0034);
        mdl[0] = 16'h0034;

        busCycle(1'b1, mkAddr(1'b0, 4'h0, 2'd3), 1'b1, 16'h0000, 1'b0, 1'b0, 3, ack, vpa, rd, oe, oeAck);
        chk("id_read",   32'(rd),    32'h5753);
        chk("id_oe_ack", 32'(oeAck), 32'd1);
        chk("id_ack",    32'(ack),   32'd6);

        busCycle(1'b1, mkAddr(1'b0, 4'h0, 2'd3), 1'b0, 16'hFFFF, 1'b0, 1'b0, 3, ack, vpa, rd, oe, oeAck);
        chk("idw_ack",  32'(ack), 32'd6);
        chk("idw_cfgs", 32'({CFG0, CFG1}), 32'h0034A55A);

        busCycle(1'b1, mkAddr(1'b0, 4'h0, 2'd1), 1'b0, 16'h0000, 1'b1, 1'b1, 3, ack, vpa, rd, oe, oeAck);
        chk("nostrobe_ack",  32'(ack),  32'd6);
        chk("nostrobe_cfg1", 32'(CFG1), 32'hA55A);

        // VPA read of reg1 and its release.
        busCycle(1'b1, mkAddr(1'b1, 4'h0, 2'd1), 1'b1, 16'h0000, 1'b0, 1'b0, 0, ack, vpa, rd, oe, oeAck);
        chk("vpa_tick",   32'(vpa), 32'd3);
        chk("vpa_nodtk",  32'(ack), 32'd0);
        chk("vpa_rd",     32'(rd),  32'hA55A);
        chk("vpa_oe",     32'(oe),  32'd1);
        tick(); tick();
        chk("vpa_hold", 32'({nVPA, DOE}), 32'b01);
        tick();
        chk("vpa_rel",  32'({nVPA, DOE, nDTACK}), 32'b101);

        busCycle(1'b1, mkAddr(1'b1, 4'h5, 2'd2), 1'b0, 16'h0F0F, 1'b0, 1'b0, 3, ack, vpa, rd, oe, oeAck);
        chk("vpaw_cfg2", 32'(CFG2), 32'h0F0F);
        chk("vpaw_tick", 32'(vpa),  32'd3);
        mdl[2] = 16'h0F0F;

        busCycle(1'b0, mkAddr(1'b0, 4'h0, 2'd0), 1'b0, 16'hFFFF, 1'b0, 1'b0, 3, ack, vpa, rd, oe, oeAck);
        chk("cs0_quiet", 32'({ack[3:0], vpa[3:0], 3'b0, oe}), 32'h0);
        chk("cs0_cfg0",  32'(CFG0), 32'h0034);

        // Reset while acknowledging, with nAS held low afterwards.
        CS = 1'b1; A = mkAddr(1'b0, 4'h0, 2'd1); RnW = 1'b0; Din = 16'h1111;
        nUDS = 1'b0; nLDS = 1'b0; nAS = 1'b0;
        repeat (6) tick();
        chk("rmid_pre_ack", 32'(nDTACK), 32'd0);
        RES = 1'b1;
        tick();
        chk("rmid_outs", 32'({nDTACK, nVPA, DOE}), 32'b110);
        chk("rmid_cfg",  32'({CFG0, CFG1} | {16'h0, CFG2}), 32'h0);
        RES = 1'b0;
        hit = 1'b0;
        repeat (12) begin
            tick();
            if (!nDTACK || !nVPA || DOE) hit = 1'b1;
        end
        chk("rmid_noretrig", 32'(hit),  32'd0);
        chk("rmid_cfg1",     32'(CFG1), 32'h0);
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) mdl[i] = 16'h0000;
        busCycle(1'b1, mkAddr(1'b0, 4'h0, 2'd1), 1'b1, 16'h0000, 1'b1, 1'b1, 3, ack, vpa, rd, oe, oeAck);
        chk("rmid_newcyc_ack", 32'(ack), 32'd6);
        chk("rmid_newcyc_rd",  32'(rd),  32'h0);

        // Back-to-back random traffic with 1-edge nAS gaps.
        for (int n = 0; n < 100; n++) begin
            idx  = 2'($urandom_range(0, 3));
            rvpa = 1'($urandom_range(0, 1));
            rrnw = 1'($urandom_range(0, 1));
            ruds = 1'($urandom_range(0, 1));
            rlds = 1'($urandom_range(0, 1));
            rdin = 16'($urandom);
            ral  = 4'($urandom_range(0, 15));
            busCycle(1'b1, mkAddr(rvpa, ral, idx), rrnw, rdin, ruds, rlds, 1, ack, vpa, rd, oe, oeAck);
            chk("rnd_term", 32'({ack[7:0], vpa[7:0]}), rvpa ? 32'h0003 : 32'h0600);
            if (rrnw) begin
                chk("rnd_rd", 32'(rd), 32'(mdl[idx]));
            end else if (idx != 2'd3) begin
                if (!ruds) mdl[idx][15:8] = rdin[15:8];
                if (!rlds) mdl[idx][7:0]  = rdin[7:0];
            end
        end
        repeat (4) tick();
        chk("rnd_cfg0", 32'(CFG0), 32'(mdl[0]));
        chk("rnd_cfg1", 32'(CFG1), 32'(mdl[1]));
        chk("rnd_cfg2", 32'(CFG2), 32'(mdl[2]));
        chk("no_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
